// File: rtl/tge_sched_pkg.sv
// Shared types and constants for the 10GbE transmit destination scheduler.
package tge_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_CTRL      = 4'd0;
  localparam logic [3:0] ADDR_LEN       = 4'd1;
  localparam logic [3:0] ADDR_NDEST     = 4'd2;
  localparam logic [3:0] ADDR_GAP       = 4'd3;
  localparam logic [3:0] ADDR_DEST_BASE = 4'd4;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // Table index width; wide enough for the largest supported table (6 entries).
  localparam int IDX_W = 3;

  function automatic logic [IDX_W-1:0] clamp_ndest(input logic [31:0] wdata, input int max_dest);
    if (wdata > 32'(max_dest)) return IDX_W'(max_dest);
    return wdata[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] eff_ndest(input logic [IDX_W-1:0] n);
    return (n == '0) ? IDX_W'(1) : n;
  endfunction

endpackage

// File: rtl/tge_dest_table.sv
// Destination IP/port register file with write decode and a registered read.
module tge_dest_table import tge_sched_pkg::*; #(
  parameter int NUM_DEST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_ip,
  output logic [15:0]      rd_port
);

  logic [31:0]      ip_q   [NUM_DEST];
  logic [15:0]      port_q [NUM_DEST];
  logic [3:0]       off;
  logic [IDX_W-1:0] wr_ent;
  logic             wr_is_ip;
  logic             wr_hit;
  logic [31:0]      sel_ip;
  logic [15:0]      sel_port;

  assign off      = cfg_addr - ADDR_DEST_BASE;
  assign wr_ent   = off[3:1];
  assign wr_is_ip = ~off[0];
  assign wr_hit   = cfg_we && (cfg_addr >= ADDR_DEST_BASE) && (wr_ent < IDX_W'(NUM_DEST));

  // A write landing this cycle is forwarded so a packet starting next cycle sees it.
  always_comb begin
    sel_ip   = '0;
    sel_port = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        sel_ip   = ip_q[i];
        sel_port = port_q[i];
      end
    end
    if (wr_hit && (wr_ent == rd_idx)) begin
      if (wr_is_ip) sel_ip = cfg_wdata;
      else          sel_port = cfg_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DEST; i++) begin
        ip_q[i]   <= '0;
        port_q[i] <= '0;
      end
      rd_ip   <= '0;
      rd_port <= '0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++) begin
        if (wr_hit && (wr_ent == IDX_W'(i))) begin
          if (wr_is_ip) ip_q[i]   <= cfg_wdata;
          else          port_q[i] <= cfg_wdata[15:0];
        end
      end
      rd_ip   <= sel_ip;
      rd_port <= sel_port;
    end
  end

endmodule

// File: rtl/tge_tx_dest_sched.sv
// Packetises a free-running 64-bit stream for the 10GbE core, inserting a gap
// between packets and stepping the destination round-robin through a table.
module tge_tx_dest_sched import tge_sched_pkg::*; #(
  parameter int NUM_DEST = 4,
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 16,
  parameter int GAP_W    = 8,
  parameter int CNT_W    = 32
) (
  input  logic              OPB_Clk,
  input  logic              OPB_Rst,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              tx_afull,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_end_of_frame,
  output logic [31:0]       tx_dest_ip,
  output logic [15:0]       tx_dest_port,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              busy
);

  // Handshake: din has no ready; a word is taken on "accept" or else dropped/discarded.
  // tx_valid qualifies tx_data for exactly one cycle and ignores tx_afull once issued.
  state_t           state_q, state_d;
  logic             enable_q;
  logic [LEN_W-1:0] len_q, cnt_q, eff_len;
  logic [IDX_W-1:0] ndest_q, idx_q, idx_d, eff_nd, wr_nd_eff;
  logic [GAP_W-1:0] gap_q, gap_cnt_q;
  logic [LEN_W:0]   cnt_inc;
  logic             wr_ctrl, wr_len, wr_nd, wr_gap, clr;
  logic             accept, start, last, drop;
  logic [31:0]      tbl_ip;
  logic [15:0]      tbl_port;

  assign wr_ctrl   = cfg_we && (cfg_addr == ADDR_CTRL);
  assign wr_len    = cfg_we && (cfg_addr == ADDR_LEN);
  assign wr_nd     = cfg_we && (cfg_addr == ADDR_NDEST);
  assign wr_gap    = cfg_we && (cfg_addr == ADDR_GAP);
  assign clr       = wr_ctrl && cfg_wdata[CTRL_CLR_BIT];
  assign wr_nd_eff = eff_ndest(clamp_ndest(cfg_wdata, NUM_DEST));

  assign eff_len = (len_q == '0) ? LEN_W'(1) : len_q;
  assign eff_nd  = eff_ndest(ndest_q);

  assign accept  = din_valid && !tx_afull &&
                   ((state_q == SEND) || ((state_q == IDLE) && enable_q));
  assign start   = accept && (state_q == IDLE);
  assign cnt_inc = start ? (LEN_W+1)'(1) : ({1'b0, cnt_q} + 1'b1);
  // ">=" so a length shrunk below the running count closes on the next word.
  assign last    = accept && (cnt_inc >= {1'b0, eff_len});
  assign drop    = din_valid && !accept && !((state_q == IDLE) && !enable_q);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, SEND: if (accept) state_d = last ? ((gap_q != '0) ? GAP : IDLE) : SEND;
      GAP:        if (gap_cnt_q <= GAP_W'(1)) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outside a packet idx names the next entry, so a shrinking table resets it now;
  // inside a packet the wrap at EOF already lands on 0.
  always_comb begin
    idx_d = idx_q;
    if (accept && last) idx_d = (idx_q >= eff_nd - 1'b1) ? '0 : idx_q + 1'b1;
    if (wr_nd && (state_d != SEND) && (idx_d >= wr_nd_eff)) idx_d = '0;
  end

  tge_dest_table #(.NUM_DEST(NUM_DEST)) u_table (
    .clk       (OPB_Clk),
    .rst       (OPB_Rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .rd_idx    (idx_d),
    .rd_ip     (tbl_ip),
    .rd_port   (tbl_port)
  );

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q         <= IDLE;
      enable_q        <= 1'b0;
      len_q           <= '0;
      ndest_q         <= '0;
      gap_q           <= '0;
      cnt_q           <= '0;
      gap_cnt_q       <= '0;
      idx_q           <= '0;
      tx_data         <= '0;
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      tx_dest_ip      <= '0;
      tx_dest_port    <= '0;
      pkt_count       <= '0;
      drop_count      <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (wr_ctrl) enable_q <= cfg_wdata[CTRL_EN_BIT];
      if (wr_len)  len_q    <= cfg_wdata[LEN_W-1:0];
      if (wr_nd)   ndest_q  <= clamp_ndest(cfg_wdata, NUM_DEST);
      if (wr_gap)  gap_q    <= cfg_wdata[GAP_W-1:0];
      if (accept)  cnt_q    <= cnt_inc[LEN_W-1:0];
      if (accept && last)         gap_cnt_q <= gap_q;
      else if (state_q == GAP)    gap_cnt_q <= gap_cnt_q - 1'b1;
      tx_valid        <= accept;
      tx_end_of_frame <= accept && last;
      if (accept) tx_data <= din;
      if (start) begin
        tx_dest_ip   <= tbl_ip;
        tx_dest_port <= tbl_port;
      end
      if (clr)                                    pkt_count <= '0;
      else if (accept && last && pkt_count != '1) pkt_count <= pkt_count + 1'b1;
      if (clr)                                    drop_count <= '0;
      else if (drop && drop_count != '1)          drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_tge_tx_dest_sched.sv
// Bench for tge_tx_dest_sched: vector tables, directed corner sequences and a
// randomized run against a packet-level reference model.
module tb_tge_tx_dest_sched;

  localparam int NUM_DEST = 4;
  localparam int DATA_W   = 64;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam logic [31:0] IP0     = 32'h0A00_0001;
  localparam logic [31:0] IP1     = 32'h0A00_0002;
  localparam logic [31:0] IP1_NEW = 32'h0A00_00FF;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              tx_afull;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_end_of_frame;
  logic [31:0]       tx_dest_ip;
  logic [15:0]       tx_dest_port;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  drop_count;
  logic              busy;

  always #5 clk = ~clk;

  tge_tx_dest_sched #(.NUM_DEST(NUM_DEST), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .din             (din),
    .din_valid       (din_valid),
    .tx_afull        (tx_afull),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_end_of_frame (tx_end_of_frame),
    .tx_dest_ip      (tx_dest_ip),
    .tx_dest_port    (tx_dest_port),
    .pkt_count       (pkt_count),
    .drop_count      (drop_count),
    .busy            (busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Reference model: configuration, table, and packet progress in plain integers.
  bit          m_en;
  int          m_len, m_gap;
  logic [31:0] m_nd;
  logic [31:0] m_ip   [NUM_DEST];
  logic [15:0] m_port [NUM_DEST];
  bit          m_in_pkt;
  int          m_words, m_gap_left, m_idx, m_pkt, m_drop;
  logic [31:0] m_cur_ip;
  logic [15:0] m_cur_port;
  bit          m_acc, m_eof;

  typedef struct {
    bit          v;
    bit          af;
    bit          e_valid;
    bit          e_eof;
    logic [31:0] e_ip;
    int          e_pkt;
    int          e_drop;
  } vec_t;

  vec_t tab1[16];
  vec_t tab3[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  task automatic model_reset();
    m_en = 0; m_len = 0; m_gap = 0; m_nd = 0;
    for (int i = 0; i < NUM_DEST; i++) begin
      m_ip[i] = '0;
      m_port[i] = '0;
    end
    m_in_pkt = 0; m_words = 0; m_gap_left = 0; m_idx = 0;
    m_pkt = 0; m_drop = 0; m_cur_ip = '0; m_cur_port = '0;
    m_acc = 0; m_eof = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [63:0] d, input bit af,
                            input bit we, input logic [3:0] a, input logic [31:0] wd);
    int eff_len, eff_nd, ent;
    eff_len = (m_len == 0) ? 1 : m_len;
    eff_nd  = (m_nd == 0) ? 1 : ((m_nd > NUM_DEST) ? NUM_DEST : int'(m_nd));
    m_acc = 0;
    m_eof = 0;
    if (m_gap_left > 0) begin
      if (v) m_drop = sat_inc(m_drop);
      m_gap_left--;
    end else if (v && (m_in_pkt || m_en)) begin
      if (af) m_drop = sat_inc(m_drop);
      else begin
        m_acc = 1;
        if (!m_in_pkt) begin
          if (m_idx >= eff_nd) m_idx = 0;
          m_cur_ip   = m_ip[m_idx];
          m_cur_port = m_port[m_idx];
          m_words    = 0;
          m_in_pkt   = 1;
        end
        m_words++;
        exp_q.push_back(d);
        if (m_words >= eff_len) begin
          m_eof      = 1;
          m_in_pkt   = 0;
          m_pkt      = sat_inc(m_pkt);
          m_idx      = (m_idx + 1 >= eff_nd) ? 0 : m_idx + 1;
          m_gap_left = m_gap;
        end
      end
    end
    if (we) begin
      case (a)
        4'd0: begin
          m_en = wd[0];
          if (wd[1]) begin
            m_pkt  = 0;
            m_drop = 0;
          end
        end
        4'd1: m_len = int'(wd[15:0]);
        4'd2: m_nd  = wd;
        4'd3: m_gap = int'(wd[7:0]);
        default: begin
          ent = (int'(a) - 4) / 2;
          if (ent < NUM_DEST) begin
            if (a[0] == 1'b0) m_ip[ent] = wd;
            else              m_port[ent] = wd[15:0];
          end
        end
      endcase
    end
  endtask

  task automatic tick(input bit v, input logic [63:0] d, input bit af,
                      input bit we, input logic [3:0] a, input logic [31:0] wd);
    din_valid = v; din = d; tx_afull = af;
    cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    model_step(v, d, af, we, a, wd);
    @(posedge clk);
    #1;
    chk("tx_valid", tx_valid, m_acc);
    if (tx_valid) begin
      chk("exp_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
    end
    chk("tx_eof", tx_end_of_frame, m_eof);
    chk("tx_dest_ip", tx_dest_ip, m_cur_ip);
    chk("tx_dest_port", tx_dest_port, m_cur_port);
    chk("pkt_count", pkt_count, m_pkt);
    chk("drop_count", drop_count, m_drop);
    chk("busy", busy, m_in_pkt || (m_gap_left > 0));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd);
    tick(0, '0, 0, 1, a, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, '0, 0, 0, 4'd0, 32'd0);
  endtask

  task automatic word(input logic [63:0] d);
    tick(1, d, 0, 0, 4'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1; din_valid = 0; din = '0; tx_afull = 0;
    cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_eof", tx_end_of_frame, 0);
    chk("rst_dest_ip", tx_dest_ip, 0);
    chk("rst_dest_port", tx_dest_port, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    // len=4, 2 dests, gap=2, continuous input: three packets with two 2-word gaps.
    tab1[0]  = '{1, 0, 1, 0, IP0, 0, 0};
    tab1[1]  = '{1, 0, 1, 0, IP0, 0, 0};
    tab1[2]  = '{1, 0, 1, 0, IP0, 0, 0};
    tab1[3]  = '{1, 0, 1, 1, IP0, 1, 0};
    tab1[4]  = '{1, 0, 0, 0, IP0, 1, 1};
    tab1[5]  = '{1, 0, 0, 0, IP0, 1, 2};
    tab1[6]  = '{1, 0, 1, 0, IP1, 1, 2};
    tab1[7]  = '{1, 0, 1, 0, IP1, 1, 2};
    tab1[8]  = '{1, 0, 1, 0, IP1, 1, 2};
    tab1[9]  = '{1, 0, 1, 1, IP1, 2, 2};
    tab1[10] = '{1, 0, 0, 0, IP1, 2, 3};
    tab1[11] = '{1, 0, 0, 0, IP1, 2, 4};
    tab1[12] = '{1, 0, 1, 0, IP0, 2, 4};
    tab1[13] = '{1, 0, 1, 0, IP0, 2, 4};
    tab1[14] = '{1, 0, 1, 0, IP0, 2, 4};
    tab1[15] = '{1, 0, 1, 1, IP0, 3, 4};
    // len=0, num_dest=0, gap=0: every word is its own packet to dest0.
    tab3[0]  = '{1, 0, 1, 1, IP0, 1, 0};
    tab3[1]  = '{1, 0, 1, 1, IP0, 2, 0};
    tab3[2]  = '{1, 0, 1, 1, IP0, 3, 0};

    rst = 1;
    din_valid = 0; din = '0; tx_afull = 0;
    cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    wr(4'd4, IP0); wr(4'd5, 32'd5000); wr(4'd6, IP1); wr(4'd7, 32'd5001);
    wr(4'd1, 32'd4); wr(4'd2, 32'd2); wr(4'd3, 32'd2); wr(4'd0, 32'd1);
    for (int k = 0; k < 16; k++) begin
      tick(tab1[k].v, 64'h100 + 64'(k), tab1[k].af, 0, 4'd0, 32'd0);
      chk("t1_valid", tx_valid, tab1[k].e_valid);
      chk("t1_eof", tx_end_of_frame, tab1[k].e_eof);
      chk("t1_ip", tx_dest_ip, tab1[k].e_ip);
      chk("t1_pkt", pkt_count, tab1[k].e_pkt);
      chk("t1_drop", drop_count, tab1[k].e_drop);
    end

    // tx_afull for 3 cycles mid-packet: 3 drops, packet still closes after 4 words.
    idle(3);
    wr(4'd0, 32'd3);
    word(64'h200); word(64'h201);
    for (int i = 0; i < 3; i++) tick(1, 64'h2F0 + 64'(i), 1, 0, 4'd0, 32'd0);
    word(64'h202);
    chk("afull_eof_early", tx_end_of_frame, 0);
    word(64'h203);
    chk("afull_eof", tx_end_of_frame, 1);
    chk("afull_drop", drop_count, 3);
    chk("afull_pkt", pkt_count, 1);
    chk("afull_ip", tx_dest_ip, IP1);

    // Entry 1 rewritten while it is in use: old IP kept, new IP on next use.
    idle(2);
    for (int i = 0; i < 4; i++) word(64'h300 + 64'(i));
    idle(2);
    word(64'h310);
    tick(1, 64'h311, 0, 1, 4'd6, IP1_NEW);
    word(64'h312); word(64'h313);
    chk("rewrite_old_ip", tx_dest_ip, IP1);
    chk("rewrite_old_eof", tx_end_of_frame, 1);
    idle(2);
    for (int i = 0; i < 4; i++) word(64'h320 + 64'(i));
    chk("rewrite_dest0_ip", tx_dest_ip, IP0);
    idle(2);
    word(64'h330);
    chk("rewrite_new_ip", tx_dest_ip, IP1_NEW);
    for (int i = 1; i < 4; i++) word(64'h330 + 64'(i));
    idle(3);

    wr(4'd1, 32'd0); wr(4'd2, 32'd0); wr(4'd3, 32'd0); wr(4'd0, 32'd3);
    for (int k = 0; k < 3; k++) begin
      tick(tab3[k].v, 64'h400 + 64'(k), tab3[k].af, 0, 4'd0, 32'd0);
      chk("t3_valid", tx_valid, tab3[k].e_valid);
      chk("t3_eof", tx_end_of_frame, tab3[k].e_eof);
      chk("t3_ip", tx_dest_ip, tab3[k].e_ip);
      chk("t3_pkt", pkt_count, tab3[k].e_pkt);
      chk("t3_drop", drop_count, tab3[k].e_drop);
    end

    // Reset mid-packet (dest1, 2 of 4 words), then the next packet starts at dest0.
    wr(4'd1, 32'd4); wr(4'd2, 32'd2);
    for (int i = 0; i < 4; i++) word(64'h500 + 64'(i));
    word(64'h510); word(64'h511);
    chk("pre_rst_ip", tx_dest_ip, IP1_NEW);
    chk("pre_rst_busy", busy, 1);
    do_reset();
    wr(4'd4, IP0); wr(4'd5, 32'd5000); wr(4'd1, 32'd4); wr(4'd2, 32'd2); wr(4'd0, 32'd1);
    word(64'h520);
    chk("post_rst_ip", tx_dest_ip, IP0);
    chk("post_rst_port", tx_dest_port, 5000);
    word(64'h521); word(64'h522);
    chk("post_rst_eof_early", tx_end_of_frame, 0);
    word(64'h523);
    chk("post_rst_eof", tx_end_of_frame, 1);

    // Saturation, then a clear coincident with an EOF.
    wr(4'd1, 32'd1); wr(4'd3, 32'd0); wr(4'd0, 32'd3);
    for (int i = 0; i < CNT_MAX + 2; i++) word(64'h600 + 64'(i));
    chk("pkt_saturated", pkt_count, CNT_MAX);
    tick(1, 64'h6FF, 0, 1, 4'd0, 32'd3);
    chk("clr_vs_eof_eof", tx_end_of_frame, 1);
    chk("clr_vs_eof_pkt", pkt_count, 0);
    for (int i = 0; i < CNT_MAX + 2; i++) tick(1, 64'h700, 1, 0, 4'd0, 32'd0);
    chk("drop_saturated", drop_count, CNT_MAX);

    // Randomized run with occasional register writes, checked by the model.
    for (int r = 0; r < 6; r++) begin
      idle(4);
      wr(4'd1, 32'(  $urandom_range(0, 5)));
      wr(4'd2, 32'(  $urandom_range(0, 7)));
      wr(4'd3, 32'(  $urandom_range(0, 3)));
      for (int e = 0; e < NUM_DEST; e++) begin
        wr(4'(4 + 2 * e), $urandom);
        wr(4'(5 + 2 * e), $urandom);
      end
      wr(4'd0, 32'd3);
      for (int c = 0; c < 300; c++) begin
        logic [3:0]  a;
        logic [31:0] wd;
        bit          we;
        we = ($urandom_range(0, 19) == 0);
        a  = 4'($urandom_range(0, 15));
        case (a)
          4'd0:    wd = {30'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0)};
          4'd1:    wd = 32'($urandom_range(0, 5));
          4'd2:    wd = 32'($urandom_range(0, 7));
          4'd3:    wd = 32'($urandom_range(0, 3));
          default: wd = $urandom;
        endcase
        tick($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) < 2, we, a, wd);
      end
    end

    idle(8);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
